// File: rtl/midi_pkg.sv
// midi_pkg
// Shared definitions for the MIDI note transmitter:
//   MIDI_NOTE_ON / MIDI_NOTE_OFF : status byte high nibbles (channel is ORed in later)
//   tx_state_t                   : message FSM states (IDLE, OFF, ON)
//   midi_div()                   : clock cycles per MIDI bit, truncated
package midi_pkg;

    localparam logic [7:0] MIDI_NOTE_ON  = 8'h90;
    localparam logic [7:0] MIDI_NOTE_OFF = 8'h80;

    typedef enum logic [1:0] {
        IDLE,
        OFF,
        ON
    } tx_state_t;

    function automatic int midi_div(input int f_clk, input int baud);
        return f_clk / baud;
    endfunction

endpackage

// File: rtl/midi_note_tx_if.sv
// midi_note_tx_if
// Bundles the note-detector side and the serial side of the MIDI transmitter.
//   midi[6:0] : note number (don't-care while note_on is low)
//   note_on   : a note is present
//   tx        : MIDI serial line, idle high
//   busy      : a message (or Off/On pair) is on the wire
// master drives the note inputs and watches the line; slave is the transmitter.
interface midi_note_tx_if;
    import midi_pkg::*;

    logic [6:0] midi;
    logic       note_on;
    logic       tx;
    logic       busy;

    modport master (output midi, output note_on, input tx, input busy);
    modport slave  (input midi, input note_on, output tx, output busy);

endinterface

// File: rtl/midi_note_tx_uart_tx.sv
// uart_tx
// 8N1 byte serialiser, LSB first, each bit held DIV clocks.
//   clk, reset : clock and synchronous active-high reset
//   data[7:0]  : byte to send, taken when valid is accepted
//   valid      : request to send data
//   ready      : pulses in the last cycle of a stop bit
//   tx         : serial line, idle high
// A byte offered while ready is high starts straight after the stop bit, so
// a caller that keeps valid up on ready gets back-to-back frames.
module uart_tx
    import midi_pkg::*;
#(
    parameter int DIV = 384
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       bitIdx_q, bitIdx_d;
    logic [7:0]       data_q, data_d;
    logic             active_q, active_d;
    logic             tx_q, tx_d;
    logic             load;

    assign ready = active_q && (bitIdx_q == 4'd9) && (cnt_q == CNT_LAST);
    assign load  = valid && (!active_q || ready);
    assign tx    = tx_q;

    // Frame sequencing: bitIdx 0 is the start bit, 1..8 the data bits and 9 the
    // stop bit. The line value for the next bit is registered at the bit boundary
    // so tx is a clean flop output.
    always_comb begin
        cnt_d    = cnt_q;
        bitIdx_d = bitIdx_q;
        data_d   = data_q;
        active_d = active_q;
        tx_d     = tx_q;
        if (load) begin
            active_d = 1'b1;
            data_d   = data;
            bitIdx_d = 4'd0;
            cnt_d    = '0;
            tx_d     = 1'b0;
        end else if (active_q) begin
            if (cnt_q == CNT_LAST) begin
                cnt_d = '0;
                if (bitIdx_q == 4'd9) begin
                    active_d = 1'b0;
                    tx_d     = 1'b1;
                end else begin
                    bitIdx_d = bitIdx_q + 4'd1;
                    tx_d     = (bitIdx_q == 4'd8) ? 1'b1 : data_q[bitIdx_q[2:0]];
                end
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers; reset abandons any frame and returns the line to idle.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q    <= '0;
            bitIdx_q <= 4'd0;
            data_q   <= 8'd0;
            active_q <= 1'b0;
            tx_q     <= 1'b1;
        end else begin
            cnt_q    <= cnt_d;
            bitIdx_q <= bitIdx_d;
            data_q   <= data_d;
            active_q <= active_d;
            tx_q     <= tx_d;
        end
    end

endmodule

// File: rtl/midi_note_tx.sv
// midi_note_tx
// Turns note-state changes from the note detector into MIDI Note On / Note Off
// messages on a single serial pin.
//   clk, reset : clock and synchronous active-high reset
//   bus        : slave side of midi_note_tx_if (midi, note_on in; tx, busy out)
// Parameters: F_CLK / BAUD set the bit period, CHANNEL is ORed into the status
// nibble, VELOCITY is the Note On velocity. Changes seen while a message is in
// flight are not queued; only the input value at the next idle sample counts.
module midi_note_tx
    import midi_pkg::*;
#(
    parameter int F_CLK    = 12_000_000,
    parameter int BAUD     = 31_250,
    parameter int CHANNEL  = 0,
    parameter int VELOCITY = 100
) (
    input  logic           clk,
    input  logic           reset,
    midi_note_tx_if.slave  bus
);

    localparam int DIV = midi_div(F_CLK, BAUD);

    tx_state_t  state_q, state_d;
    logic [1:0] byteIdx_q, byteIdx_d;
    logic       launched_q, launched_d;
    logic       pair_q, pair_d;
    logic [6:0] offNote_q, offNote_d;
    logic [6:0] onNote_q, onNote_d;
    logic       rep_on_q, rep_on_d;
    logic [6:0] rep_note_q, rep_note_d;
    logic       noteOnIn_q;
    logic [6:0] midiIn_q;

    logic       needOff, needOn;
    logic       uartValid, uartReady;
    logic [7:0] uartData;

    function automatic logic [7:0] msgByte(input tx_state_t st, input logic [1:0] idx,
                                           input logic [6:0] note);
        logic [7:0] b;
        case (idx)
            2'd0:    b = ((st == ON) ? MIDI_NOTE_ON : MIDI_NOTE_OFF) | 8'(CHANNEL % 16);
            2'd1:    b = {1'b0, note};
            default: b = (st == ON) ? 8'(VELOCITY) : 8'h00;
        endcase
        return b;
    endfunction

    // The short-circuit forms keep an undriven midi (note_on low) out of the decision.
    assign needOff = noteOnIn_q ? (rep_on_q && (midiIn_q != rep_note_q)) : rep_on_q;
    assign needOn  = noteOnIn_q && (!rep_on_q || (midiIn_q != rep_note_q));

    // Message FSM. launched_q marks that the current state's bytes are on the wire;
    // the first byte is handed over while the serialiser is idle, every later byte
    // (including the On of an Off/On pair) in the ready cycle of the previous stop
    // bit, which keeps the frames contiguous. The reported note state is committed
    // when a message is decided, not when it finishes.
    always_comb begin
        state_d    = state_q;
        byteIdx_d  = byteIdx_q;
        launched_d = launched_q;
        pair_d     = pair_q;
        offNote_d  = offNote_q;
        onNote_d   = onNote_q;
        rep_on_d   = rep_on_q;
        rep_note_d = rep_note_q;
        uartValid  = 1'b0;
        uartData   = msgByte(state_q, byteIdx_q, (state_q == ON) ? onNote_q : offNote_q);
        case (state_q)
            IDLE: begin
                if (needOff || needOn) begin
                    state_d    = needOff ? OFF : ON;
                    byteIdx_d  = 2'd0;
                    launched_d = 1'b0;
                    pair_d     = needOff && needOn;
                    offNote_d  = rep_note_q;
                    rep_on_d   = needOn;
                    if (needOn) begin
                        onNote_d   = midiIn_q;
                        rep_note_d = midiIn_q;
                    end
                end
            end
            OFF, ON: begin
                if (!launched_q) begin
                    uartValid  = 1'b1;
                    launched_d = 1'b1;
                end else if (uartReady) begin
                    if (byteIdx_q != 2'd2) begin
                        uartValid = 1'b1;
                        uartData  = msgByte(state_q, byteIdx_q + 2'd1,
                                            (state_q == ON) ? onNote_q : offNote_q);
                        byteIdx_d = byteIdx_q + 2'd1;
                    end else if ((state_q == OFF) && pair_q) begin
                        uartValid = 1'b1;
                        uartData  = msgByte(ON, 2'd0, onNote_q);
                        state_d   = ON;
                        byteIdx_d = 2'd0;
                        pair_d    = 1'b0;
                    end else begin
                        state_d    = IDLE;
                        byteIdx_d  = 2'd0;
                        launched_d = 1'b0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Registers. The inputs are registered once so the comparator sees stable
    // values; reset forgets any sounding note without sending its Note Off.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            byteIdx_q  <= 2'd0;
            launched_q <= 1'b0;
            pair_q     <= 1'b0;
            offNote_q  <= 7'd0;
            onNote_q   <= 7'd0;
            rep_on_q   <= 1'b0;
            rep_note_q <= 7'd0;
            noteOnIn_q <= 1'b0;
            midiIn_q   <= 7'd0;
        end else begin
            state_q    <= state_d;
            byteIdx_q  <= byteIdx_d;
            launched_q <= launched_d;
            pair_q     <= pair_d;
            offNote_q  <= offNote_d;
            onNote_q   <= onNote_d;
            rep_on_q   <= rep_on_d;
            rep_note_q <= rep_note_d;
            noteOnIn_q <= bus.note_on;
            midiIn_q   <= bus.midi;
        end
    end

    assign bus.busy = launched_q;

    uart_tx #(.DIV(DIV)) u_uart (
        .clk   (clk),
        .reset (reset),
        .data  (uartData),
        .valid (uartValid),
        .ready (uartReady),
        .tx    (bus.tx)
    );

endmodule

// File: tb/tb_midi_note_tx.sv
// tb_midi_note_tx
// Drives midi_note_tx through directed note scenarios and a random note stream.
// A message-level model predicts, for every cycle, the expected tx level and
// busy from the note-event rules; directed sections decode the line and pin
// the byte values and latencies to hand-worked constants.
module tb_midi_note_tx;
    import midi_pkg::*;

    localparam int F_CLK    = 520_000;
    localparam int BAUD     = 31_250;
    localparam int CHANNEL  = 9;
    localparam int VELOCITY = 100;
    localparam int DIV      = F_CLK / BAUD;
    localparam int MSG_CYC  = 30 * DIV;

    logic clk = 1'b0;
    logic reset = 1'b1;

    midi_note_tx_if bus();

    midi_note_tx #(
        .F_CLK    (F_CLK),
        .BAUD     (BAUD),
        .CHANNEL  (CHANNEL),
        .VELOCITY (VELOCITY)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    int cyc = 0;
    bit modelValid = 0;
    bit repOn = 0;
    int repNote = 0;
    int msgStart = -1_000_000;
    int msgLen = 0;
    int freeAt = 0;
    int msgBytes[6];

    logic [7:0] rxBytes[6];

    // Compare one value and report a failure in a single line.
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] required);
        compared++;
        if (actual !== required) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, required, cyc);
        end
    endtask

    task automatic applyStimulus(input logic on, input logic [6:0] note);
        bus.note_on = on;
        bus.midi    = on ? note : 7'bx;
    endtask

    // Expected line level after edge c: frame bits of the scheduled message, else idle.
    function automatic logic expTx(input int c);
        int bi, by, pos;
        if (c < msgStart || c >= msgStart + msgLen) return 1'b1;
        bi  = (c - msgStart) / DIV;
        by  = bi / 10;
        pos = bi % 10;
        if (pos == 0) return 1'b0;
        if (pos == 9) return 1'b1;
        return 1'((msgBytes[by] >> (pos - 1)) & 1);
    endfunction

    function automatic logic expBusy(input int c);
        return (c >= msgStart && c < msgStart + msgLen);
    endfunction

    // Message model: at each edge where the transmitter is free it applies the
    // note-event rules to the inputs present at that edge and schedules the
    // resulting bytes two edges later, one byte per 10 bit periods.
    initial begin
        bit needOff, needOn, on;
        int n, m;
        forever begin
            @(posedge clk);
            cyc++;
            if (reset) begin
                repOn      = 0;
                repNote    = 0;
                msgStart   = -1_000_000;
                msgLen     = 0;
                freeAt     = cyc + 1;
                modelValid = 1;
            end else if (cyc >= freeAt) begin
                on      = (bus.note_on === 1'b1);
                m       = on ? int'(bus.midi) : 0;
                needOn  = on && (!repOn || m != repNote);
                needOff = repOn && (!on || m != repNote);
                n = 0;
                if (needOff) begin
                    msgBytes[0] = 8'h80 | CHANNEL;
                    msgBytes[1] = repNote;
                    msgBytes[2] = 0;
                    n = 3;
                end
                if (needOn) begin
                    msgBytes[n]     = 8'h90 | CHANNEL;
                    msgBytes[n + 1] = m;
                    msgBytes[n + 2] = VELOCITY;
                    n += 3;
                    repNote = m;
                end
                if (n > 0) begin
                    repOn    = on;
                    msgStart = cyc + 2;
                    msgLen   = n * 10 * DIV;
                    freeAt   = msgStart + msgLen;
                end
            end
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (modelValid) begin
                checkOutput("tx_model", bus.tx, expTx(cyc));
                checkOutput("busy_model", bus.busy, expBusy(cyc));
            end
        end
    end

    task automatic waitCyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic waitStart(input int budget, output int s);
        s = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (bus.tx === 1'b0) begin
                s = cyc;
                break;
            end
        end
        if (s < 0) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL start_timeout: no start bit within %0d cycles", budget);
        end
    endtask

    // Decode n contiguous frames whose first start bit began at edge s.
    task automatic receiveBytes(input int n, input int s);
        logic v;
        for (int j = 0; j < n; j++) begin
            for (int b = 0; b < 10; b++) begin
                waitCyc(s + (10 * j + b) * DIV + DIV / 2);
                v = bus.tx;
                if (b == 0) checkOutput("start_bit", v, 0);
                else if (b == 9) checkOutput("stop_bit", v, 1);
                else rxBytes[j][b - 1] = v;
            end
        end
    endtask

    task automatic countLows(input int len, output int lows);
        lows = 0;
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            if (bus.tx !== 1'b1) lows++;
        end
    endtask

    initial begin
        int c0, s, lows, r;
        logic on;
        bus.note_on = 1'b0;
        bus.midi    = 7'd0;
        reset       = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_tx", bus.tx, 1);
        checkOutput("reset_busy", bus.busy, 0);
        reset = 1'b0;

        countLows(3000, lows);
        checkOutput("idle_quiet", lows, 0);
        checkOutput("idle_busy", bus.busy, 0);

        // A440 on, with a short release pulse while it is being sent
        c0 = cyc;
        applyStimulus(1'b1, 7'd69);
        waitStart(10, s);
        checkOutput("on_latency", s, c0 + 3);
        checkOutput("on_busy_rise", bus.busy, 1);
        fork
            receiveBytes(3, s);
            begin
                waitCyc(s + 5 * DIV);
                bus.note_on = 1'b0;
                repeat (100) @(negedge clk);
                bus.note_on = 1'b1;
            end
        join
        checkOutput("on_status", rxBytes[0], 8'h99);
        checkOutput("on_note", rxBytes[1], 8'h45);
        checkOutput("on_vel", rxBytes[2], 8'h64);
        waitCyc(s + MSG_CYC - 1);
        checkOutput("on_busy_last", bus.busy, 1);
        waitCyc(s + MSG_CYC);
        checkOutput("on_busy_fall", bus.busy, 0);
        countLows(3 * MSG_CYC, lows);
        checkOutput("coalesce_quiet", lows, 0);

        // Release
        c0 = cyc;
        applyStimulus(1'b0, 7'd0);
        waitStart(10, s);
        checkOutput("off_latency", s, c0 + 3);
        receiveBytes(3, s);
        checkOutput("off_status", rxBytes[0], 8'h89);
        checkOutput("off_note", rxBytes[1], 8'h45);
        checkOutput("off_vel", rxBytes[2], 8'h00);
        waitCyc(s + MSG_CYC + 2);

        // Note change 69 -> 71: Off then On, contiguous
        applyStimulus(1'b1, 7'd69);
        waitStart(10, s);
        waitCyc(s + MSG_CYC + 2);
        c0 = cyc;
        applyStimulus(1'b1, 7'd71);
        waitStart(10, s);
        checkOutput("pair_latency", s, c0 + 3);
        receiveBytes(6, s);
        checkOutput("pair_b0", rxBytes[0], 8'h89);
        checkOutput("pair_b1", rxBytes[1], 8'h45);
        checkOutput("pair_b2", rxBytes[2], 8'h00);
        checkOutput("pair_b3", rxBytes[3], 8'h99);
        checkOutput("pair_b4", rxBytes[4], 8'h47);
        checkOutput("pair_b5", rxBytes[5], 8'h64);
        waitCyc(s + 2 * MSG_CYC - 1);
        checkOutput("pair_busy_last", bus.busy, 1);
        waitCyc(s + 2 * MSG_CYC);
        checkOutput("pair_busy_fall", bus.busy, 0);
        waitCyc(s + 2 * MSG_CYC + 2);

        // Reset in bit 4 of byte 2 of a Note Off
        applyStimulus(1'b0, 7'd0);
        waitStart(10, s);
        waitCyc(s + 24 * DIV + DIV / 2);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("midreset_tx", bus.tx, 1);
        checkOutput("midreset_busy", bus.busy, 0);
        reset = 1'b0;
        countLows(200, lows);
        checkOutput("midreset_quiet", lows, 0);
        c0 = cyc;
        applyStimulus(1'b1, 7'd60);
        waitStart(10, s);
        checkOutput("c4_latency", s, c0 + 3);
        receiveBytes(3, s);
        checkOutput("c4_status", rxBytes[0], 8'h99);
        checkOutput("c4_note", rxBytes[1], 8'h3C);
        checkOutput("c4_vel", rxBytes[2], 8'h64);
        waitCyc(s + MSG_CYC + 2);

        // Random note stream, checked cycle by cycle against the model
        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 19);
            if (r == 0) begin
                reset = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                reset = 1'b0;
            end else begin
                on = ($urandom_range(0, 2) != 0);
                if (r < 4) applyStimulus(on, 7'($urandom_range(0, 127)));
                else applyStimulus(on, 7'($urandom_range(60, 63)));
            end
            repeat ($urandom_range(1, MSG_CYC + 40)) @(negedge clk);
        end
        repeat (2 * MSG_CYC + 10) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
